merge_rr_n: RTL

//   N-input fair merge primitive for the xMAS network library; parametrised successor of the 2-input merge.

---
 rtl/merge_rr_n.sv | 98 +++++++++
 1 files changed

// File: rtl/merge_rr_n.sv
// N-input round-robin merge for irdy/trdy channels.
// The grant is held on a stalled packet until it transfers; dropping it early sets a sticky error.
module merge_rr_n #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2,
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_irdy,
  output logic [N-1:0]    i_trdy,
  input  logic [N*W-1:0]  i_data,
  output logic            o0_irdy,
  input  logic            o0_trdy,
  output logic [W-1:0]    o0_data,
  output logic [SELW-1:0] sel,
  output logic            err
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] lsel_q, lsel_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;

  logic            any_req;
  logic            locked;
  logic            viol;
  logic            found;
  logic [SELW-1:0] free_sel;
  logic [SELW-1:0] sel_arb;
  logic [N-1:0]    grant;
  int unsigned     idx;

  // Round-robin scan starting at ptr_q, wrapping modulo N.
  always_comb begin
    any_req  = |i_irdy;
    locked   = lock_q && i_irdy[lsel_q];
    viol     = lock_q && !i_irdy[lsel_q];
    found    = 1'b0;
    free_sel = ptr_q;
    idx      = 0;
    for (int unsigned j = 0; j < N; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && i_irdy[SELW'(idx)]) begin
        found    = 1'b1;
        free_sel = SELW'(idx);
      end
    end
    sel_arb = locked ? lsel_q : free_sel;
  end

  // Outputs are forced quiet while in reset; o0_trdy only reaches i_trdy.
  always_comb begin
    sel     = rst ? '0 : sel_arb;
    o0_irdy = !rst && any_req;
    grant   = '0;
    o0_data = '0;
    for (int k = 0; k < N; k++) begin
      if (SELW'(k) == sel) begin
        grant[k] = 1'b1;
        o0_data  = i_data[k*W +: W];
      end
    end
    i_trdy = (o0_trdy && !rst) ? (grant & i_irdy) : '0;
    err    = err_q;
  end

  always_comb begin
    ptr_d  = ptr_q;
    lsel_d = lsel_q;
    lock_d = 1'b0;
    err_d  = err_q | viol;
    if (any_req && o0_trdy) begin
      ptr_d = (sel_arb == SELW'(N - 1)) ? '0 : sel_arb + 1'b1;
    end else if (any_req) begin
      lock_d = 1'b1;
      lsel_d = sel_arb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      lsel_q <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lsel_q <= lsel_d;
      lock_q <= lock_d;
      err_q  <= err_d;
    end
  end

endmodule
